lcd_ctrl_param: RTL
===================

Name: lcd_ctrl_param

Overview:
- Parametrised successor to the fixed 8x8 LCD controller.
- Loads an IMG_W x IMG_H image of DW-bit pixels from the image ROM into an internal frame buffer.
- Executes host commands on a 2x2 window around a movable operation point, then streams the frame to the image RAM on WRITE.
- Unlike the fixed block, it returns to command mode after WRITE, so several frames can be written without reloading. Unknown opcodes are defined no-ops.

Parameters:
- IMG_W, 8, image width in pixels; ≥2, power of two.
- IMG_H, 8, image height in pixels; ≥2, power of two.
- DW, 8, pixel width in bits.
- AW, 6, address width; must equal log2(IMG_W*IMG_H).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd  in  4  command opcode.
- cmd_valid  in  1  cmd qualifier.
- irom_q  in  DW  ROM read data; valid the cycle after irom_a is presented.
- irom_rd  out  1  ROM read enable.
- irom_a  out  AW  ROM address.
- iram_valid  out  1  RAM write strobe.
- iram_d  out  DW  RAM write data.
- iram_a  out  AW  RAM write address.
- busy  out  1  high = command not accepted.
- done  out  1  one-cycle pulse after the last RAM write.

Behaviour:
- Reset values: busy=1, done=0, irom_rd=0, irom_a=0, iram_valid=0, iram_d=0, iram_a=0.
- Reset state: point (x,y)=(IMG_W/2, IMG_H/2), buffer cleared, FSM=LOAD.
- Window pixel indices: UL=(y-1)*IMG_W+(x-1), UR=UL+1, LL=UL+IMG_W, LR=LL+1.
- x range 1..IMG_W-1; y range 1..IMG_H-1.
- FSM states: LOAD -> WAIT -> EXEC -> WAIT; WRITE -> DONE -> WAIT.
- LOAD:
  - irom_rd=1; irom_a steps 0..N-1 (N=IMG_W*IMG_H), one address per cycle.
  - buffer[k] captures irom_q one cycle after irom_a=k.
  - irom_rd drops after address N-1 is issued. After the last capture, go to WAIT.
  - busy stays 1 throughout.
- WAIT:
  - busy=0. cmd is accepted only when cmd_valid=1 on an edge where busy=0.
  - busy=1 from the cycle after acceptance. cmd_valid while busy=1 is ignored.
- EXEC: every non-WRITE command takes exactly 1 cycle. busy returns to 0 on the second cycle after acceptance.
- Opcodes:
  - 0 WRITE.
  - 1 up (y-1), 2 down (y+1), 3 left (x-1), 4 right (x+1); each saturates at its range bound, no wrap.
  - 5 MAX, 6 MIN: all four window pixels take the max/min of the four.
  - 7 AVG: sum in DW+2 bits, floor(sum/4), written to all four.
  - 8 CCW rotate: UL<=UR, UR<=LR, LR<=LL, LL<=UL.
  - 9 CW rotate: UL<=LL, LL<=LR, LR<=UR, UR<=UL.
  - 10 mirror-X: swap rows. 11 mirror-Y: swap columns.
  - 12-15: no-op with 1-cycle busy, unless the optional feature is enabled.
- WRITE:
  - iram_valid=1 for exactly N consecutive cycles, starting the cycle after acceptance.
  - iram_a=0..N-1 with iram_d=buffer[iram_a], all in the same cycle.
  - Cycle after the last write: iram_valid=0 and done=1 for one cycle (DONE), then WAIT with busy=0.
  - Buffer and point are preserved.
- Reset asserted mid-LOAD, EXEC or WRITE: outputs go to reset values immediately; the FSM restarts LOAD after release.

Optional Feature:
- Macro: LCD_CTRL_BRIGHT_EN.
- Defined:
  - opcode 12 = BRIGHTEN: each window pixel +1, saturating at 2^DW-1.
  - opcode 13 = DARKEN: each window pixel -1, saturating at 0.
  - Both take 1 cycle, like other EXEC commands.
- Undefined: 12 and 13 are no-ops like 14-15.

Test Plan:
- Reset, ROM pixel k=k (8x8 default) -> irom_a 0..63 sequential, busy falls one cycle after the last capture; then WRITE -> iram_a/iram_d pairs (k,k) for k=0..63, then done pulse, then busy=0.
- Default point: MAX then WRITE -> RAM addresses 27,28,35,36 = 36; all others unchanged. Repeat from reset with AVG -> all four = 31 (126/4).
- Left x5 then WRITE -> x saturates at 1; next MIN touches indices 24,25,32,33, all = 24. Right x10 -> x=7, indices 30,31,38,39.
- CW rotate on default window -> 27=35, 28=27, 36=28, 35=36. Mirror-X twice -> original image restored.
- cmd_valid held high with opcodes 14 and 2 during busy -> only the first accepted command executes. Reset_n pulsed mid-WRITE at iram_a=20 -> outputs go to reset values and LOAD restarts from irom_a=0.
- With LCD_CTRL_BRIGHT_EN, pixel 36 preloaded 255 -> BRIGHTEN leaves 255 and raises 27 to 28. Without the macro -> opcode 12 leaves the image unchanged, busy high 1 cycle.

Source files
------------

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD controller: loads an IMG_W x IMG_H frame from ROM, edits a 2x2 window on command, streams it to RAM.
// Optional BRIGHTEN/DARKEN opcodes are enabled by defining LCD_CTRL_BRIGHT_EN.
module lcd_ctrl_param #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] irom_q,
    output logic          irom_rd,
    output logic [AW-1:0] irom_a,
    output logic          iram_valid,
    output logic [DW-1:0] iram_d,
    output logic [AW-1:0] iram_a,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [AW:0]   N_CNT = (AW+1)'(N);
    localparam logic [AW-1:0] LAST  = AW'(N - 1);

    typedef enum logic [2:0] {S_LOAD, S_WAIT, S_EXEC, S_WRITE, S_DONE} state_t;

    typedef enum logic [3:0] {
        OP_WRITE  = 4'd0,  OP_UP    = 4'd1,  OP_DOWN  = 4'd2,  OP_LEFT   = 4'd3,
        OP_RIGHT  = 4'd4,  OP_MAX   = 4'd5,  OP_MIN   = 4'd6,  OP_AVG    = 4'd7,
        OP_CCW    = 4'd8,  OP_CW    = 4'd9,  OP_MIRX  = 4'd10, OP_MIRY   = 4'd11,
        OP_BRIGHT = 4'd12, OP_DARK  = 4'd13, OP_NOP14 = 4'd14, OP_NOP15  = 4'd15
    } op_t;

    state_t          state, state_nxt;
    op_t             op_q;
    logic [XW-1:0]   x, x_nxt;
    logic [YW-1:0]   y, y_nxt;
    logic [AW:0]     issue_cnt;
    logic            cap_valid;
    logic [AW-1:0]   cap_addr;
    logic [AW-1:0]   wr_cnt;
    logic [DW-1:0]   buffer [0:N-1];

    // Window addressing: with power-of-two dimensions the UL index is just {y-1, x-1}.
    logic [XW-1:0]   x_m1;
    logic [YW-1:0]   y_m1;
    logic [AW-1:0]   ul, ur, ll, lr;
    logic [DW-1:0]   p_ul, p_ur, p_ll, p_lr;
    logic [DW-1:0]   n_ul, n_ur, n_ll, n_lr;
    logic [DW-1:0]   mx, mn;
    logic [DW+1:0]   sum;
    logic            win_we;

    assign x_m1 = x - XW'(1);
    assign y_m1 = y - YW'(1);
    assign ul   = {y_m1, x_m1};
    assign ur   = ul + AW'(1);
    assign ll   = ul + AW'(IMG_W);
    assign lr   = ll + AW'(1);
    assign p_ul = buffer[ul];
    assign p_ur = buffer[ur];
    assign p_ll = buffer[ll];
    assign p_lr = buffer[lr];

`ifdef LCD_CTRL_BRIGHT_EN
    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] p);
        return (&p) ? p : p + 1'b1;
    endfunction

    function automatic logic [DW-1:0] sat_dec(input logic [DW-1:0] p);
        return (p == '0) ? p : p - 1'b1;
    endfunction
`endif

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_LOAD;
        else          state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        done       = 1'b0;
        iram_valid = 1'b0;
        iram_a     = '0;
        iram_d     = '0;
        case (state)
            S_LOAD:  if (cap_valid && cap_addr == LAST) state_nxt = S_WAIT;
            S_WAIT: begin
                busy = 1'b0;
                if (cmd_valid) state_nxt = (cmd == 4'd0) ? S_WRITE : S_EXEC;
            end
            S_EXEC:  state_nxt = S_WAIT;
            S_WRITE: begin
                iram_valid = 1'b1;
                iram_a     = wr_cnt;
                iram_d     = buffer[wr_cnt];
                if (wr_cnt == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Window reductions feeding MAX/MIN/AVG.
    always_comb begin
        mx = p_ul;
        if (p_ur > mx) mx = p_ur;
        if (p_ll > mx) mx = p_ll;
        if (p_lr > mx) mx = p_lr;
        mn = p_ul;
        if (p_ur < mn) mn = p_ur;
        if (p_ll < mn) mn = p_ll;
        if (p_lr < mn) mn = p_lr;
        sum = {2'b00, p_ul} + {2'b00, p_ur} + {2'b00, p_ll} + {2'b00, p_lr};
    end

    always_comb begin
        x_nxt  = x;
        y_nxt  = y;
        win_we = 1'b0;
        n_ul   = p_ul;
        n_ur   = p_ur;
        n_ll   = p_ll;
        n_lr   = p_lr;
        case (op_q)
            OP_UP:    if (y > YW'(1))          y_nxt = y - YW'(1);
            OP_DOWN:  if (y < YW'(IMG_H - 1))  y_nxt = y + YW'(1);
            OP_LEFT:  if (x > XW'(1))          x_nxt = x - XW'(1);
            OP_RIGHT: if (x < XW'(IMG_W - 1))  x_nxt = x + XW'(1);
            OP_MAX: begin
                win_we = 1'b1;
                {n_ul, n_ur, n_ll, n_lr} = {4{mx}};
            end
            OP_MIN: begin
                win_we = 1'b1;
                {n_ul, n_ur, n_ll, n_lr} = {4{mn}};
            end
            OP_AVG: begin
                win_we = 1'b1;
                {n_ul, n_ur, n_ll, n_lr} = {4{sum[DW+1:2]}};
            end
            OP_CCW: begin
                win_we = 1'b1;
                n_ul = p_ur; n_ur = p_lr; n_lr = p_ll; n_ll = p_ul;
            end
            OP_CW: begin
                win_we = 1'b1;
                n_ul = p_ll; n_ll = p_lr; n_lr = p_ur; n_ur = p_ul;
            end
            OP_MIRX: begin
                win_we = 1'b1;
                n_ul = p_ll; n_ll = p_ul; n_ur = p_lr; n_lr = p_ur;
            end
            OP_MIRY: begin
                win_we = 1'b1;
                n_ul = p_ur; n_ur = p_ul; n_ll = p_lr; n_lr = p_ll;
            end
`ifdef LCD_CTRL_BRIGHT_EN
            OP_BRIGHT: begin
                win_we = 1'b1;
                n_ul = sat_inc(p_ul); n_ur = sat_inc(p_ur);
                n_ll = sat_inc(p_ll); n_lr = sat_inc(p_lr);
            end
            OP_DARK: begin
                win_we = 1'b1;
                n_ul = sat_dec(p_ul); n_ur = sat_dec(p_ur);
                n_ll = sat_dec(p_ll); n_lr = sat_dec(p_lr);
            end
`endif
            default: ;
        endcase
    end

    // ROM fetch pipeline, command latch, point and write counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irom_rd   <= 1'b0;
            irom_a    <= '0;
            issue_cnt <= '0;
            cap_valid <= 1'b0;
            cap_addr  <= '0;
            op_q      <= OP_WRITE;
            x         <= XW'(IMG_W / 2);
            y         <= YW'(IMG_H / 2);
            wr_cnt    <= '0;
        end else begin
            cap_valid <= (state == S_LOAD) && irom_rd;
            cap_addr  <= irom_a;
            case (state)
                S_LOAD: begin
                    if (issue_cnt < N_CNT) begin
                        irom_rd   <= 1'b1;
                        irom_a    <= issue_cnt[AW-1:0];
                        issue_cnt <= issue_cnt + 1'b1;
                    end else begin
                        irom_rd   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    wr_cnt <= '0;
                    if (cmd_valid) op_q <= op_t'(cmd);
                end
                S_EXEC: begin
                    x <= x_nxt;
                    y <= y_nxt;
                end
                S_WRITE: wr_cnt <= wr_cnt + AW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the frame buffer is reset on purpose, since a cleared buffer is part of the reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) buffer[i] <= '0;
        end else if (state == S_LOAD && cap_valid) begin
            buffer[cap_addr] <= irom_q;
        end else if (state == S_EXEC && win_we) begin
            buffer[ul] <= n_ul;
            buffer[ur] <= n_ur;
            buffer[ll] <= n_ll;
            buffer[lr] <= n_lr;
        end
    end

endmodule
